// File: rtl/sha256_round_initiator.sv
// Register-bus initiator for one SHA-256 round job: writes A..H, W and K into the
// responder window, waits SETTLE idle cycles, reads back the new A..H and returns it.
module sha256_round_initiator #(
  parameter logic [15:0] BASE_ADDR = 16'h4000,
  parameter int unsigned SETTLE    = 2
) (
  input  logic         ACLK,
  input  logic         ARST,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [255:0] job_state,
  input  logic [31:0]  job_w,
  input  logic [31:0]  job_k,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [255:0] res_state,
  output logic         busy,
  output logic [15:0]  WRADDR,
  output logic [3:0]   BYTEEN,
  output logic         WREN,
  output logic [31:0]  WDATA,
  output logic [15:0]  RDADDR,
  output logic         RDEN,
  input  logic [31:0]  RDATA,
  output logic [2:0]   dbg_state
);

  // Handshakes: a transfer happens on a rising ACLK edge where valid and ready are
  // both high; valid never depends on ready, and payload is held stable while valid.

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_SETTLE, S_READ, S_DRAIN, S_DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

  state_t       state;
  logic [3:0]   beat;
  logic [3:0]   beat_nx;
  logic [2:0]   cap_idx;
  logic [255:0] st_q;
  logic [31:0]  w_q;
  logic [31:0]  k_q;

  assign beat_nx   = beat + 4'd1;
  // RDATA seen during a beat belongs to the previous read beat; beat 0 of DRAIN maps to word 7.
  assign cap_idx   = beat[2:0] - 3'd1;
  assign dbg_state = state;

  function automatic logic [15:0] wr_addr(input logic [3:0] b);
    case (b)
      4'd8:    return BASE_ADDR + 16'h0044;
      4'd9:    return BASE_ADDR + 16'h0048;
      default: return BASE_ADDR + {10'd0, b, 2'b00};
    endcase
  endfunction

  function automatic logic [31:0] wr_data(input logic [3:0] b, input logic [255:0] s,
                                          input logic [31:0] w, input logic [31:0] k);
    case (b)
      4'd8:    return w;
      4'd9:    return k;
      default: return s[{~b[2:0], 5'd0} +: 32];
    endcase
  endfunction

  function automatic logic [15:0] rd_addr(input logic [2:0] b);
    return BASE_ADDR + 16'h0020 + {11'd0, b, 2'b00};
  endfunction

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state     <= S_IDLE;
      beat      <= 4'd0;
      st_q      <= '0;
      w_q       <= '0;
      k_q       <= '0;
      job_ready <= 1'b0;
      res_valid <= 1'b0;
      res_state <= '0;
      busy      <= 1'b0;
      WREN      <= 1'b0;
      RDEN      <= 1'b0;
      BYTEEN    <= 4'h0;
      WRADDR    <= '0;
      RDADDR    <= '0;
      WDATA     <= '0;
    end else begin
      WREN   <= 1'b0;
      RDEN   <= 1'b0;
      BYTEEN <= 4'h0;
      WRADDR <= '0;
      RDADDR <= '0;
      WDATA  <= '0;
      case (state)
        S_IDLE: begin
          job_ready <= 1'b1;
          if (job_valid && job_ready) begin
            st_q      <= job_state;
            w_q       <= job_w;
            k_q       <= job_k;
            job_ready <= 1'b0;
            busy      <= 1'b1;
            beat      <= 4'd0;
            state     <= S_WRITE;
            WREN      <= 1'b1;
            BYTEEN    <= 4'hF;
            WRADDR    <= wr_addr(4'd0);
            WDATA     <= wr_data(4'd0, job_state, job_w, job_k);
          end
        end
        S_WRITE: begin
          if (beat == 4'd9) begin
            beat <= 4'd0;
            if (SETTLE == 0) begin
              state  <= S_READ;
              RDEN   <= 1'b1;
              RDADDR <= rd_addr(3'd0);
            end else begin
              state <= S_SETTLE;
            end
          end else begin
            beat   <= beat_nx;
            WREN   <= 1'b1;
            BYTEEN <= 4'hF;
            WRADDR <= wr_addr(beat_nx);
            WDATA  <= wr_data(beat_nx, st_q, w_q, k_q);
          end
        end
        S_SETTLE: begin
          if (beat == SETTLE_LAST) begin
            beat   <= 4'd0;
            state  <= S_READ;
            RDEN   <= 1'b1;
            RDADDR <= rd_addr(3'd0);
          end else begin
            beat <= beat_nx;
          end
        end
        S_READ: begin
          if (beat != 4'd0) res_state[{~cap_idx, 5'd0} +: 32] <= RDATA;
          if (beat == 4'd7) begin
            beat  <= 4'd0;
            state <= S_DRAIN;
          end else begin
            beat   <= beat_nx;
            RDEN   <= 1'b1;
            RDADDR <= rd_addr(beat_nx[2:0]);
          end
        end
        S_DRAIN: begin
          res_state[{~cap_idx, 5'd0} +: 32] <= RDATA;
          res_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            job_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_round_initiator.sv
// Bench for sha256_round_initiator: bus responder model, expected-result and bus-beat
// queues filled at issue/acceptance, negedge monitors pop and compare.
module tb_sha256_round_initiator;

  localparam logic [15:0] BASE = 16'h4000;
  localparam int          SET  = 2;

  localparam logic [255:0] S_ABC   = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [31:0]  W_ABC   = 32'h61626380;
  localparam logic [31:0]  K_ABC   = 32'h428a2f98;
  localparam logic [255:0] EXP_ABC = 256'h5d6aebcd6a09e667bb67ae853c6ef372fa2a4622510e527f9b05688c1f83d9ab;

  localparam logic [255:0] S_V2 = 256'h0123456789abcdeffedcba987654321000000000ffffffffa5a5a5a55a5a5a5a;
  localparam logic [255:0] S_V3 = 256'h11111111222222223333333344444444555555556666666677777777_88888888;

  // ---------------- clock / reset ----------------
  logic ACLK = 1'b0;
  logic ARST = 1'b1;
  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  // ---------------- DUT (SETTLE = SET) ----------------
  logic         job_valid = 1'b0, job_ready, res_valid, res_ready = 1'b1, busy;
  logic [255:0] job_state = '0, res_state;
  logic [31:0]  job_w = '0, job_k = '0, WDATA, RDATA = '0;
  logic [15:0]  WRADDR, RDADDR;
  logic [3:0]   BYTEEN;
  logic         WREN, RDEN;
  logic [2:0]   dbg_state;

  sha256_round_initiator #(.BASE_ADDR(BASE), .SETTLE(SET)) dut (
    .ACLK(ACLK), .ARST(ARST), .job_valid(job_valid), .job_ready(job_ready),
    .job_state(job_state), .job_w(job_w), .job_k(job_k), .res_valid(res_valid),
    .res_ready(res_ready), .res_state(res_state), .busy(busy), .WRADDR(WRADDR),
    .BYTEEN(BYTEEN), .WREN(WREN), .WDATA(WDATA), .RDADDR(RDADDR), .RDEN(RDEN),
    .RDATA(RDATA), .dbg_state(dbg_state)
  );

  // ---------------- DUT (SETTLE = 0) ----------------
  logic         jv0 = 1'b0, jr0, rv0, rr0 = 1'b0, busy0;
  logic [255:0] js0 = '0, rs0;
  logic [31:0]  jw0 = '0, jk0 = '0, WDATA0, RDATA0 = '0;
  logic [15:0]  WRADDR0, RDADDR0;
  logic [3:0]   BYTEEN0;
  logic         WREN0, RDEN0;
  logic [2:0]   dbg_state0;

  sha256_round_initiator #(.BASE_ADDR(BASE), .SETTLE(0)) dut0 (
    .ACLK(ACLK), .ARST(ARST), .job_valid(jv0), .job_ready(jr0),
    .job_state(js0), .job_w(jw0), .job_k(jk0), .res_valid(rv0),
    .res_ready(rr0), .res_state(rs0), .busy(busy0), .WRADDR(WRADDR0),
    .BYTEEN(BYTEEN0), .WREN(WREN0), .WDATA(WDATA0), .RDADDR(RDADDR0), .RDEN(RDEN0),
    .RDATA(RDATA0), .dbg_state(dbg_state0)
  );

  // ---------------- reference round + responder model ----------------
  function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] w,
                                             input logic [31:0] k);
    logic [31:0] a, b, c, d, e, f, g, h, s0, s1, ch, mj, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    s1 = {e[5:0], e[31:6]} ^ {e[10:0], e[31:11]} ^ {e[24:0], e[31:25]};
    ch = (e & f) ^ (~e & g);
    t1 = h + s1 + ch + k + w;
    s0 = {a[1:0], a[31:2]} ^ {a[12:0], a[31:13]} ^ {a[21:0], a[31:22]};
    mj = (a & b) ^ (a & c) ^ (b & c);
    t2 = s0 + mj;
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  function automatic int reg_idx(input logic [15:0] a);
    logic [15:0] off;
    off = a - BASE;
    return int'(off[15:2]);
  endfunction

  function automatic logic [31:0] resp_word(input logic [18:0][31:0] m, input logic [15:0] a);
    logic [255:0] r;
    int           j;
    r = sha_round({m[0], m[1], m[2], m[3], m[4], m[5], m[6], m[7]}, m[17], m[18]);
    j = reg_idx(a) - 8;
    if (j < 0 || j > 7) return 32'hbad0bad0;
    return r[255 - 32*j -: 32];
  endfunction

  logic [18:0][31:0] mem = '0, mem0 = '0;

  always @(posedge ACLK) begin
    if (WREN && reg_idx(WRADDR) <= 18) mem[reg_idx(WRADDR)] <= WDATA;
    RDATA <= RDEN ? resp_word(mem, RDADDR) : 32'hdeadbeef;
    if (WREN0 && reg_idx(WRADDR0) <= 18) mem0[reg_idx(WRADDR0)] <= WDATA0;
    RDATA0 <= RDEN0 ? resp_word(mem0, RDADDR0) : 32'hdeadbeef;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          cyc;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] data;
  } beat_t;

  logic [255:0] exp_q[$];
  int           lat_q[$];
  beat_t        bus_q[$];
  int           acc_hist[$];
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input int act, input int exp);
    checks++;
    errors++;
    $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Acceptance monitor: derives expected bus beats and result latency from cycle c.
  always @(negedge ACLK) begin
    if (!ARST && job_valid && job_ready) begin
      acc_hist.push_back(cyc);
      lat_q.push_back(cyc + 20 + SET);
      for (int i = 0; i < 8; i++)
        bus_q.push_back(beat_t'{cyc + 1 + i, 1'b1, 16'(BASE + 4*i), job_state[255 - 32*i -: 32]});
      bus_q.push_back(beat_t'{cyc + 9, 1'b1, 16'(BASE + 16'h44), job_w});
      bus_q.push_back(beat_t'{cyc + 10, 1'b1, 16'(BASE + 16'h48), job_k});
      for (int i = 0; i < 8; i++)
        bus_q.push_back(beat_t'{cyc + 11 + SET + i, 1'b0, 16'(BASE + 16'h20 + 4*i), 32'h0});
    end
  end

  // Bus monitor.
  beat_t mb;
  always @(negedge ACLK) begin
    if (ARST) begin
      bus_q.delete();
    end else begin
      while (bus_q.size() > 0 && bus_q[0].cyc < cyc) begin
        mb = bus_q.pop_front();
        fail("missed_beat", cyc, mb.cyc);
      end
      if (WREN && RDEN) fail("strobe_overlap", 1, 0);
      if (WREN || RDEN) begin
        if (bus_q.size() == 0) begin
          fail("unexpected_beat", cyc, -1);
        end else begin
          mb = bus_q.pop_front();
          chk("beat_cycle", cyc, mb.cyc);
          chk("beat_kind_wren", WREN, mb.wr);
          chk("beat_addr", WREN ? WRADDR : RDADDR, mb.addr);
          chk("beat_other_addr", WREN ? RDADDR : WRADDR, 16'h0);
          chk("beat_wdata", WDATA, mb.wr ? mb.data : 32'h0);
          chk("beat_byteen", BYTEEN, mb.wr ? 4'hF : 4'h0);
        end
      end else begin
        chk("idle_bus", {WRADDR, RDADDR, WDATA, BYTEEN}, 68'h0);
      end
    end
  end

  // Result monitor.
  logic [255:0] held;
  logic         rv_prev = 1'b0, post_hs = 1'b0, busy_exp = 1'b0;
  int           exp_lat;
  always @(negedge ACLK) begin
    if (ARST) begin
      exp_q.delete();
      lat_q.delete();
      rv_prev  = 1'b0;
      post_hs  = 1'b0;
      busy_exp = 1'b0;
    end else begin
      chk("busy", busy, busy_exp);
      if (post_hs) chk("after_handshake_ready_valid", {job_ready, res_valid}, 2'b10);
      if (res_valid && !rv_prev) begin
        if (exp_q.size() == 0 || lat_q.size() == 0) begin
          fail("unexpected_result", cyc, -1);
        end else begin
          chk("res_state", res_state, exp_q.pop_front());
          exp_lat = lat_q.pop_front();
          chk("res_valid_cycle", cyc, exp_lat);
        end
        held = res_state;
      end else if (res_valid) begin
        chk("res_state_hold", res_state, held);
        chk("job_ready_while_done", job_ready, 1'b0);
      end
      if (job_valid && job_ready) busy_exp = 1'b1;
      if (res_valid && res_ready) busy_exp = 1'b0;
      post_hs = res_valid && res_ready;
      rv_prev = res_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_job(input logic [255:0] s, input logic [31:0] w, input logic [31:0] k,
                          input logic [255:0] exp, input bit keep_valid);
    int t = 0;
    exp_q.push_back(exp);
    job_state = s;
    job_w     = w;
    job_k     = k;
    job_valid = 1'b1;
    while (!job_ready && t < 100) begin
      @(negedge ACLK);
      t++;
    end
    if (!job_ready) fail("job_accept_timeout", t, 100);
    @(posedge ACLK);
    #1;
    if (!keep_valid) job_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge ACLK);
      t++;
    end while ((exp_q.size() != 0 || res_valid || busy) && t < 200);
    if (t >= 200) fail("idle_timeout", t, 200);
  endtask

  // ---------------- stimulus ----------------
  int t0, c0, first_rd, rv_cyc;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("reset_outputs", {job_ready, res_valid, busy, WREN, RDEN, BYTEEN, WRADDR, RDADDR, WDATA},
        73'h0);
    chk("reset_res_state", res_state, 256'h0);
    chk("reset_dbg_state", dbg_state, 3'd0);
    @(posedge ACLK);
    #1 ARST = 1'b0;
    @(negedge ACLK);
    chk("job_ready_reset_release", job_ready, 1'b0);
    @(negedge ACLK);
    chk("job_ready_after_reset", job_ready, 1'b1);

    // "abc" round 0 with full bus-trace checking.
    send_job(S_ABC, W_ABC, K_ABC, EXP_ABC, 1'b0);
    wait_idle();

    // Backpressure: hold res_ready low for 15 cycles once the result is up.
    res_ready = 1'b0;
    send_job(S_V2, 32'hcafef00d, 32'h71374491, sha_round(S_V2, 32'hcafef00d, 32'h71374491), 1'b0);
    t0 = 0;
    while (!res_valid && t0 < 60) begin
      @(negedge ACLK);
      t0++;
    end
    chk("bp_res_valid_seen", res_valid, 1'b1);
    for (int i = 0; i < 15; i++) begin
      @(negedge ACLK);
      chk("bp_res_valid_held", {res_valid, job_ready}, 2'b10);
    end
    @(posedge ACLK);
    #1 res_ready = 1'b1;
    wait_idle();

    // Back-to-back jobs with job_valid held high.
    send_job(S_ABC, W_ABC, K_ABC, EXP_ABC, 1'b1);
    send_job(S_V3, 32'h00000000, 32'hffffffff, sha_round(S_V3, 32'h0, 32'hffffffff), 1'b0);
    chk("b2b_period", acc_hist[acc_hist.size()-1] - acc_hist[acc_hist.size()-2], 21 + SET);
    wait_idle();

    // Reset during write beat 5, then a fresh job.
    send_job(S_V2, 32'h12345678, 32'h9abcdef0, 256'h0, 1'b0);
    repeat (5) @(posedge ACLK);
    #1;
    chk("beat5_wraddr", WRADDR, 16'h4014);
    ARST = 1'b1;
    @(posedge ACLK);
    #1 ARST = 1'b0;
    @(negedge ACLK);
    chk("midreset_outputs", {WREN, RDEN, busy, res_valid, job_ready}, 5'b0);
    chk("midreset_res_state", res_state, 256'h0);
    @(negedge ACLK);
    chk("midreset_job_ready", job_ready, 1'b1);
    send_job(S_ABC, W_ABC, K_ABC, EXP_ABC, 1'b0);
    wait_idle();

    // SETTLE = 0 instance.
    js0 = S_ABC;
    jw0 = W_ABC;
    jk0 = K_ABC;
    jv0 = 1'b1;
    rr0 = 1'b1;
    t0  = 0;
    while (!jr0 && t0 < 50) begin
      @(negedge ACLK);
      t0++;
    end
    c0 = cyc;
    @(posedge ACLK);
    #1 jv0 = 1'b0;
    first_rd = -1;
    rv_cyc   = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge ACLK);
      if (RDEN0 && first_rd < 0) first_rd = cyc;
      if (rv0) begin
        rv_cyc = cyc;
        break;
      end
    end
    chk("s0_first_read_cycle", first_rd, c0 + 11);
    chk("s0_res_valid_cycle", rv_cyc, c0 + 20);
    chk("s0_res_state", rs0, EXP_ABC);
    @(negedge ACLK);
    chk("s0_after_handshake", {jr0, rv0}, 2'b10);

    chk("exp_q_drained", exp_q.size(), 0);
    chk("bus_q_drained", bus_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
